track_sequencer: RTL and testbench
==================================

# track_sequencer

Control block for one tracking channel. It sequences the C/A-wipe-off accumulator datapath through clear, integrate and dump phases. It latches the PRN and integration length on a start request, gates the datapath enable and reset, and counts A/D sample strobes to close each accumulation epoch. It captures the datapath accumulator into a result register and hands it to the loop-filter/CPU side over a valid/ready handshake.

## Interface
Parameters:
- ACC_WIDTH, 16, width of datapath accumulator and dump result
- EPOCH_WIDTH, 16, width of samples-per-epoch count (50400 = 3 ms at 16.8 MHz fits)
- CLEAR_CYCLES, 2, cycles trk_reset is held after start

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; all state and outputs to reset values
- start  in  1  one-cycle request: latch prn_in/epoch_len, begin tracking
- stop  in  1  one-cycle request: return to IDLE
- prn_in  in  5  PRN for the channel
- epoch_len  in  EPOCH_WIDTH  samples per accumulation; values 0 and 1 are clamped to 2
- sample_valid  in  1  A/D sample strobe, at most one per two clk cycles
- acc_in  in  ACC_WIDTH  datapath accumulator value
- trk_enable  out  1  datapath enable
- trk_reset  out  1  datapath clear, active-high
- trk_prn  out  5  latched PRN to datapath
- dump_valid  out  1  result available
- dump_ready  in  1  consumer accepts result
- dump_value  out  ACC_WIDTH  captured accumulator
- dump_overrun  out  1  sticky: result overwritten before acceptance
- sample_lost  out  1  sticky: sample_valid during CLEAR or DUMP
- busy  out  1  state != IDLE
- epoch_count  out  16  completed epochs (see Configuration)

## Operation
- States: IDLE, CLEAR, RUN, DUMP.
- IDLE: trk_enable=0, trk_reset=1. A start moves to CLEAR.
- CLEAR: latch trk_prn and the clamped epoch length. Load the clear counter. trk_reset=1, trk_enable=0 for CLEAR_CYCLES cycles, then RUN with the sample counter at 0.
- RUN: trk_enable=1, trk_reset=0. The sample counter increments on each sample_valid. When sample_valid arrives with counter == len-1, the next state is DUMP.
- DUMP, one cycle: dump_value<=acc_in (this value already includes the last sample), dump_valid<=1, trk_reset=1, counter<=0, epoch_count++. If dump_valid is already 1 and dump_ready is 0 this cycle, set dump_overrun. Next state is RUN.
- Handshake: dump_valid drops the cycle after dump_valid&dump_ready. dump_value is stable while dump_valid=1, except on overwrite.
- stop, from any state: IDLE next cycle. dump_valid and dump_value are retained.
- start while busy restarts at CLEAR with the new PRN/length. Any pending result is retained.
- start and stop in the same cycle: stop wins.
- start clears dump_overrun, sample_lost and epoch_count.
- sample_valid in CLEAR or DUMP is dropped and sets sample_lost.
- Counter arithmetic is unsigned EPOCH_WIDTH with no wrap, because the counter resets at len-1. epoch_count wraps modulo 2^16.

## Timing
- Reset values: state IDLE, trk_enable=0, trk_reset=1, trk_prn=0, dump_valid=0, dump_value=0, dump_overrun=0, sample_lost=0, busy=0, epoch_count=0.
- All outputs are registered.
- Sequence: start at cycle t → CLEAR at t+1..t+CLEAR_CYCLES → RUN at t+CLEAR_CYCLES+1.
- Final sample of an epoch at cycle n → DUMP at n+1 → dump_valid=1 from n+2.
- Epoch period is exactly len samples. Epoch 1 starts at the first sample in RUN.
- Reset asserted mid-epoch forces IDLE immediately and discards the partial accumulation.

## Configuration
- TRACK_EPOCH_COUNT_EN defined: the 16-bit epoch_count register is implemented as described.
- TRACK_EPOCH_COUNT_EN undefined: no counter logic; epoch_count is tied to 0.

## Structure
- Shared package track_pkg holds:
  - ACC_WIDTH default and CA_RATE_INC (DDS phase increment)
  - state encoding (IDLE/CLEAR/RUN/DUMP)
  - CLEAR_CYCLES default
  - minimum epoch length constant (2)
- One sub-module: track_epoch_counter.
  - Ports: load, len, tick; outputs terminal and count.
  - Provides the clamped sample counter.
- The FSM, dump register and handshake live in track_sequencer.

## Test plan
- Reset low mid-RUN → next edge: IDLE, trk_reset=1, dump_valid=0, epoch_count=0.
- start, prn_in=7, epoch_len=4, sample_valid every 2nd cycle, acc_in=0x0123 in DUMP → trk_prn=7, trk_reset high 2 cycles, dump_value=0x0123 two cycles after the 4th sample, epoch_count=1.
- dump_ready held 0 across two epochs → second dump overwrites value, dump_overrun=1; next start clears it.
- epoch_len=0 → behaves as 2: dump after every 2 samples.
- sample_valid in CLEAR cycle → sample_lost=1, first epoch still counts 4 RUN samples.
- start and stop same cycle while RUN → IDLE, pending dump_valid retained until dump_ready.

Source files
------------

// File: rtl/track_pkg.sv
// Shared constants and types for the tracking-channel sequencer.
package track_pkg;

  localparam int ACC_WIDTH_DEF    = 16;
  localparam int EPOCH_WIDTH_DEF  = 16;
  localparam int CLEAR_CYCLES_DEF = 2;

  // Shortest accumulation epoch; shorter requested lengths are clamped up to this.
  localparam int MIN_EPOCH_LEN    = 2;

  // C/A code DDS phase increment: 1.023 MHz chip rate at 16.8 MHz, 32-bit phase.
  localparam logic [31:0] CA_RATE_INC = 32'd261532830;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DUMP  = 2'd3
  } track_state_e;

endpackage

// File: rtl/track_epoch_counter.sv
// Sample counter for one accumulation epoch. The epoch length is latched
// (clamped to MIN_EPOCH_LEN) on load; terminal flags the tick that closes
// the epoch, and the count returns to zero on that same tick.
module track_epoch_counter
  import track_pkg::*;
#(
  parameter int WIDTH = EPOCH_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] len,
  input  logic             tick,
  output logic             terminal,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // len_q is never below MIN_EPOCH_LEN, so len_q-1 cannot underflow
  assign terminal = tick && !load && (cnt_q == len_q - WIDTH'(1));
  assign count    = cnt_q;

  // Next-state: load takes priority over counting
  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (load) begin
      len_d = (len < WIDTH'(MIN_EPOCH_LEN)) ? WIDTH'(MIN_EPOCH_LEN) : len;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = terminal ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Counter and latched length registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= WIDTH'(MIN_EPOCH_LEN);
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/track_sequencer.sv
// Tracking-channel control: sequences the accumulator datapath through
// CLEAR / RUN / DUMP, captures each epoch result and offers it over a
// valid/ready handshake.
// Optional feature macro: TRACK_EPOCH_COUNT_EN (enables the epoch_count register;
// when undefined epoch_count is tied to zero).
module track_sequencer
  import track_pkg::*;
#(
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int EPOCH_WIDTH  = EPOCH_WIDTH_DEF,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [4:0]             prn_in,
  input  logic [EPOCH_WIDTH-1:0] epoch_len,
  input  logic                   sample_valid,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  output logic                   trk_enable,
  output logic                   trk_reset,
  output logic [4:0]             trk_prn,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [ACC_WIDTH-1:0]   dump_value,
  output logic                   dump_overrun,
  output logic                   sample_lost,
  output logic                   busy,
  output logic [15:0]            epoch_count
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

  track_state_e           state_q, state_d;
  logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic [4:0]             prn_q, prn_d;
  logic                   en_q, en_d;
  logic                   rst_q, rst_d;
  logic                   busy_q, busy_d;
  logic                   dv_q, dv_d;
  logic [ACC_WIDTH-1:0]   dval_q, dval_d;
  logic                   ovr_q, ovr_d;
  logic                   lost_q, lost_d;

  logic                   start_go;
  logic                   dump_cycle;
  logic                   tick;
  logic                   terminal;
  logic [EPOCH_WIDTH-1:0] epoch_cnt;

  // stop beats a simultaneous start
  assign start_go   = start && !stop;
  assign dump_cycle = (state_q == ST_DUMP);
  assign tick       = sample_valid && (state_q == ST_RUN);

  track_epoch_counter #(
    .WIDTH (EPOCH_WIDTH)
  ) u_epoch_counter (
    .clk      (clk),
    .rst_n    (reset),
    .load     (start_go),
    .len      (epoch_len),
    .tick     (tick),
    .terminal (terminal),
    .count    (epoch_cnt)
  );

  // Next-state and registered-output values; outputs are derived from state_d
  // so they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_IDLE:  ;
      ST_CLEAR: begin
        if (clr_cnt_q == '0) state_d = ST_RUN;
        else                 clr_cnt_d = clr_cnt_q - CLR_W'(1);
      end
      ST_RUN:   if (terminal) state_d = ST_DUMP;
      ST_DUMP:  state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (start_go) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = CLR_LOAD;
    end
    if (stop) state_d = ST_IDLE;

    prn_d  = start_go ? prn_in : prn_q;
    en_d   = (state_d == ST_RUN);
    rst_d  = (state_d != ST_RUN);
    busy_d = (state_d != ST_IDLE);

    dv_d   = dv_q;
    dval_d = dval_q;
    if (dump_cycle) begin
      dv_d   = 1'b1;
      dval_d = acc_in;
    end else if (dv_q && dump_ready) begin
      dv_d   = 1'b0;
    end

    ovr_d = ovr_q;
    if (start_go)                                ovr_d = 1'b0;
    else if (dump_cycle && dv_q && !dump_ready)  ovr_d = 1'b1;

    lost_d = lost_q;
    if (start_go) lost_d = 1'b0;
    else if (sample_valid && (state_q == ST_CLEAR || state_q == ST_DUMP)) lost_d = 1'b1;
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      prn_q     <= '0;
      en_q      <= 1'b0;
      rst_q     <= 1'b1;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      dval_q    <= '0;
      ovr_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      prn_q     <= prn_d;
      en_q      <= en_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      dval_q    <= dval_d;
      ovr_q     <= ovr_d;
      lost_q    <= lost_d;
    end
  end

`ifdef TRACK_EPOCH_COUNT_EN
  logic [15:0] epoch_q, epoch_d;

  // Completed-epoch counter, wraps modulo 2^16
  always_comb begin
    epoch_d = epoch_q;
    if (start_go)        epoch_d = '0;
    else if (dump_cycle) epoch_d = epoch_q + 16'd1;
  end

  // Epoch count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) epoch_q <= '0;
    else        epoch_q <= epoch_d;
  end

  assign epoch_count = epoch_q;
`else
  assign epoch_count = '0;
`endif

  assign trk_enable   = en_q;
  assign trk_reset    = rst_q;
  assign trk_prn      = prn_q;
  assign busy         = busy_q;
  assign dump_valid   = dv_q;
  assign dump_value   = dval_q;
  assign dump_overrun = ovr_q;
  assign sample_lost  = lost_q;

  // A DUMP is only ever entered on the terminal tick, which zeroes the counter
  a_dump_count_zero: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_DUMP) |-> (epoch_cnt == '0));

endmodule

// File: tb/tb_track_sequencer.sv
// Directed, table-driven bench for track_sequencer.
module tb_track_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [4:0]  prn_in;
  logic [15:0] epoch_len;
  logic        sample_valid;
  logic [15:0] acc_in;
  logic        dump_ready;
  logic        trk_enable, trk_reset;
  logic [4:0]  trk_prn;
  logic        dump_valid;
  logic [15:0] dump_value;
  logic        dump_overrun, sample_lost, busy;
  logic [15:0] epoch_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] J = 16'hBAD1; // junk accumulator value outside DUMP

  track_sequencer #(
    .ACC_WIDTH    (16),
    .EPOCH_WIDTH  (16),
    .CLEAR_CYCLES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .prn_in       (prn_in),
    .epoch_len    (epoch_len),
    .sample_valid (sample_valid),
    .acc_in       (acc_in),
    .trk_enable   (trk_enable),
    .trk_reset    (trk_reset),
    .trk_prn      (trk_prn),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_value   (dump_value),
    .dump_overrun (dump_overrun),
    .sample_lost  (sample_lost),
    .busy         (busy),
    .epoch_count  (epoch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp;
    logic [4:0]  prn;
    logic [15:0] len;
    logic        sv;
    logic [15:0] acc;
    logic        rdy;
    logic        en, rs;
    logic [4:0]  tprn;
    logic        dv;
    logic [15:0] dval;
    logic        ovr, lost, bsy;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  // Expected epoch_count, depending on whether the counter is built in
  function automatic logic [15:0] e(input int n);
`ifdef TRACK_EPOCH_COUNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  function automatic vec_t mk(
    input logic st, sp, input logic [4:0] prn, input logic [15:0] len,
    input logic sv, input logic [15:0] acc, input logic rdy,
    input logic en, rs, input logic [4:0] tprn, input logic dv,
    input logic [15:0] dval, input logic ovr, lost, bsy, input int ec);
    vec_t v;
    v.st = st; v.sp = sp; v.prn = prn; v.len = len; v.sv = sv; v.acc = acc; v.rdy = rdy;
    v.en = en; v.rs = rs; v.tprn = tprn; v.dv = dv; v.dval = dval;
    v.ovr = ovr; v.lost = lost; v.bsy = bsy; v.ec = e(ec);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, rs, input logic [4:0] tprn,
                         input logic dv, input logic [15:0] dval,
                         input logic ovr, lost, bsy, input logic [15:0] ec);
    chk({tag, ".trk_enable"},   32'(trk_enable),   32'(en));
    chk({tag, ".trk_reset"},    32'(trk_reset),    32'(rs));
    chk({tag, ".trk_prn"},      32'(trk_prn),      32'(tprn));
    chk({tag, ".dump_valid"},   32'(dump_valid),   32'(dv));
    chk({tag, ".dump_value"},   32'(dump_value),   32'(dval));
    chk({tag, ".dump_overrun"}, 32'(dump_overrun), 32'(ovr));
    chk({tag, ".sample_lost"},  32'(sample_lost),  32'(lost));
    chk({tag, ".busy"},         32'(busy),         32'(bsy));
    chk({tag, ".epoch_count"},  32'(epoch_count),  32'(ec));
  endtask

  // Apply inputs, then advance one clock and sample 1 ns after the edge
  task automatic drive(input logic st, sp, input logic [4:0] prn, input logic [15:0] len,
                       input logic sv, input logic [15:0] acc, input logic rdy);
    start = st; stop = sp; prn_in = prn; epoch_len = len;
    sample_valid = sv; acc_in = acc; dump_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic sv, input logic [15:0] acc, input logic rdy);
    drive(1'b0, 1'b0, 5'd0, 16'd0, sv, acc, rdy);
  endtask

  initial begin
    reset = 1'b0; start = 0; stop = 0; prn_in = '0; epoch_len = '0;
    sample_valid = 0; acc_in = J; dump_ready = 0;

    // Main table: prn 7 / len 4 with a lost CLEAR sample, overrun on two
    // unread epochs, then restart with len 0 (clamped to 2)
    //                  st sp prn  len    sv acc       rdy  en rs tprn dv dval      ovr lost bsy ec
    vecs.push_back(mk(1, 0, 5'd7, 16'd4, 0, J,         0,   0, 1, 5'd7, 0, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   0, 1, 5'd7, 0, 16'h0000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   1, 0, 5'd7, 0, 16'h0000, 0, 1, 1, 0));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,       0,   1, 0, 5'd7, 0, 16'h0000, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,       0,   1, 0, 5'd7, 0, 16'h0000, 0, 1, 1, 0));
    end
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   0, 1, 5'd7, 0, 16'h0000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, 16'h0123,  0,   1, 0, 5'd7, 1, 16'h0123, 0, 1, 1, 1));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,       0,   1, 0, 5'd7, 1, 16'h0123, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,       0,   1, 0, 5'd7, 1, 16'h0123, 0, 1, 1, 1));
    end
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   0, 1, 5'd7, 1, 16'h0123, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, 16'h0456,  0,   1, 0, 5'd7, 1, 16'h0456, 1, 1, 1, 2));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         1,   1, 0, 5'd7, 0, 16'h0456, 1, 1, 1, 2));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   1, 0, 5'd7, 0, 16'h0456, 1, 1, 1, 2));
    vecs.push_back(mk(1, 0, 5'd3, 16'd0, 0, J,         0,   0, 1, 5'd3, 0, 16'h0456, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   0, 1, 5'd3, 0, 16'h0456, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   1, 0, 5'd3, 0, 16'h0456, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   1, 0, 5'd3, 0, 16'h0456, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   1, 0, 5'd3, 0, 16'h0456, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   0, 1, 5'd3, 0, 16'h0456, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, 16'h0789,  0,   1, 0, 5'd3, 1, 16'h0789, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   1, 0, 5'd3, 1, 16'h0789, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   1, 0, 5'd3, 1, 16'h0789, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         0,   1, 0, 5'd3, 1, 16'h0789, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 1, J,         0,   0, 1, 5'd3, 1, 16'h0789, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, 16'h0ABC,  1,   1, 0, 5'd3, 1, 16'h0ABC, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 5'd0, 16'd0, 0, J,         1,   1, 0, 5'd3, 0, 16'h0ABC, 0, 1, 1, 2));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 1, 5'd0, 0, 16'h0, 0, 0, 0, e(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset", 0, 1, 5'd0, 0, 16'h0, 0, 0, 0, e(0));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].prn, vecs[i].len, vecs[i].sv, vecs[i].acc, vecs[i].rdy);
      chk_all($sformatf("row%0d", i), vecs[i].en, vecs[i].rs, vecs[i].tprn, vecs[i].dv,
              vecs[i].dval, vecs[i].ovr, vecs[i].lost, vecs[i].bsy, vecs[i].ec);
    end

    // start+stop together while RUN with a pending result: stop wins, result held
    idle(1, J, 0);
    idle(0, J, 0);
    idle(1, J, 0);
    chk_all("ss_dump", 0, 1, 5'd3, 0, 16'h0ABC, 0, 1, 1, e(2));
    idle(0, 16'h0DEF, 0);
    chk_all("ss_pend", 1, 0, 5'd3, 1, 16'h0DEF, 0, 1, 1, e(3));
    drive(1, 1, 5'd9, 16'd5, 0, J, 0);
    chk_all("ss_stop", 0, 1, 5'd3, 1, 16'h0DEF, 0, 1, 0, e(3));
    idle(0, J, 0);
    idle(0, J, 0);
    chk_all("ss_hold", 0, 1, 5'd3, 1, 16'h0DEF, 0, 1, 0, e(3));
    idle(0, J, 1);
    chk_all("ss_accept", 0, 1, 5'd3, 0, 16'h0DEF, 0, 1, 0, e(3));

    // Reset mid-epoch with a pending result
    drive(1, 0, 5'd5, 16'd2, 0, J, 0);
    chk_all("rs_start", 0, 1, 5'd5, 0, 16'h0DEF, 0, 0, 1, e(0));
    idle(0, J, 0);
    idle(0, J, 0);
    idle(1, J, 0);
    idle(0, J, 0);
    idle(1, J, 0);
    idle(0, 16'h1111, 0);
    chk_all("rs_dump", 1, 0, 5'd5, 1, 16'h1111, 0, 0, 1, e(1));
    idle(1, J, 0);
    reset = 1'b0;
    #1;
    chk_all("rs_async", 0, 1, 5'd0, 0, 16'h0, 0, 0, 0, e(0));
    idle(0, J, 0);
    chk_all("rs_edge", 0, 1, 5'd0, 0, 16'h0, 0, 0, 0, e(0));
    reset = 1'b1;
    idle(1, J, 0);
    chk_all("rs_release", 0, 1, 5'd0, 0, 16'h0, 0, 0, 0, e(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
